fifo_step_player: RTL and testbench

Consumer end of the motion FIFO: pops two-word records (step mask, dwell) that the SPI front end writes and plays them out as timed step pulses on the eight motor pins. Sits between the FIFO read port and pins `p1`..`p8`. It is the only block that drives the FIFO `read_en`.

---
 rtl/fifo_step_player.sv | 100 ++++++++++
 tb/tb_fifo_step_player.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_step_player.sv
// Motion FIFO consumer: pops (step mask, dwell) records and plays each one out as
// a step pulse of PULSE_CYCLES cycles, followed by a dwell gap of dwell*TICK_DIV cycles.
module fifo_step_player #(
    parameter int WORD_SIZE    = 8,
    parameter int CHANNELS     = 8,
    parameter int PULSE_CYCLES = 12,
    parameter int TICK_DIV     = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [2*WORD_SIZE-1:0] fifo_data,
    output logic                   fifo_read_en,
    output logic [CHANNELS-1:0]    steps,
    output logic                   busy,
    output logic                   underrun,
    output logic [15:0]            records_done
);

    // state | meaning
    // IDLE  | waiting for enable and a queued record
    // FETCH | pop request to the FIFO
    // LATCH | popped record on fifo_data, load mask and pulse timer
    // PULSE | step pins high, pulse timer counting down
    // GAP   | step pins low, dwell timer counting down
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PULSE, GAP} state_t;

    localparam int DW_W  = WORD_SIZE + $clog2(TICK_DIV + 1);
    localparam int PC_W  = $clog2(PULSE_CYCLES + 1);
    localparam int CNT_W = (DW_W > PC_W) ? DW_W : PC_W;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     gap_load;
    logic [WORD_SIZE-1:0] dwell_q;
    logic                 done;

    // Full-width product so the largest dwell is never truncated.
    assign gap_load = CNT_W'(dwell_q) * CNT_W'(TICK_DIV);

    always_comb begin
        state_next   = state;
        done         = 1'b0;
        fifo_read_en = 1'b0;
        unique case (state)
            IDLE:  if (enable && !fifo_empty) state_next = FETCH;
            FETCH: begin
                fifo_read_en = !fifo_empty && !reset;
                state_next   = LATCH;
            end
            LATCH: state_next = PULSE;
            PULSE: begin
                if (cnt == '0) begin
                    if (dwell_q == '0) done = 1'b1;
                    else               state_next = GAP;
                end
            end
            GAP:   if (cnt <= CNT_W'(1)) done = 1'b1;
            default: state_next = IDLE;
        endcase
        if (done) state_next = (enable && !fifo_empty) ? FETCH : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            steps        <= '0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
            records_done <= '0;
            cnt          <= '0;
            dwell_q      <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            unique case (state)
                LATCH: begin
                    steps   <= fifo_data[CHANNELS-1:0];
                    dwell_q <= fifo_data[2*WORD_SIZE-1:WORD_SIZE];
                    cnt     <= CNT_W'(PULSE_CYCLES - 1);
                end
                PULSE: begin
                    if (cnt == '0) begin
                        steps <= '0;
                        cnt   <= gap_load;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP:   if (cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
            if (done) records_done <= records_done + 16'd1;
            underrun <= enable ? (underrun | (done && fifo_empty)) : 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_step_player.sv
// Bench for fifo_step_player: FIFO model, per-record monitor, and expected-record
// scoreboard compared record by record.
module tb_fifo_step_player;

    localparam int PULSE = 12;
    localparam int TDIV  = 12;

    typedef struct packed {
        logic [7:0]  val;
        logic [15:0] pcnt;
        logic [15:0] gcnt;
        logic        gbad;
        logic [15:0] period;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data = '0;
    logic        fifo_read_en;
    logic [7:0]  steps;
    logic        busy;
    logic        underrun;
    logic [15:0] records_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] fq[$];
    rec_t        exp_q[$];
    rec_t        obs_q[$];

    fifo_step_player dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read_en(fifo_read_en), .steps(steps),
        .busy(busy), .underrun(underrun), .records_done(records_done)
    );

    always #5 clk = ~clk;

    // FIFO model: popped word appears on fifo_data the cycle after read_en.
    always @(posedge clk) begin
        if (fifo_read_en && fq.size() > 0) fifo_data <= fq.pop_front();
    end
    always @(negedge clk) fifo_empty = (fq.size() == 0);

    // Record monitor, everything measured relative to the FETCH cycle.
    int         cyc = 0;
    int         pops = 0;
    bit         in_rec = 0;
    int         rec_start, rel, pcnt, gcnt;
    bit         gbad;
    logic [7:0] pv;
    always @(negedge clk) begin
        cyc++;
        if (fifo_read_en) pops++;
        if (reset) begin
            in_rec = 0;
        end else begin
            if (in_rec) begin
                rel = cyc - rec_start;
                if (fifo_read_en || !busy) begin
                    obs_q.push_back('{val: pv, pcnt: 16'(pcnt), gcnt: 16'(gcnt),
                                      gbad: gbad, period: 16'(rel)});
                    in_rec = 0;
                end else if (rel == 2) begin
                    pv = steps;
                    pcnt = 1;
                end else if (rel > 2 && rel < 2 + PULSE) begin
                    if (steps == pv) pcnt++;
                end else if (rel >= 2 + PULSE) begin
                    gcnt++;
                    if (steps != 8'h00) gbad = 1;
                end
            end
            if (fifo_read_en) begin
                in_rec = 1; rec_start = cyc; pcnt = 0; gcnt = 0; gbad = 0; pv = '0;
            end
        end
    end

    task automatic push_rec(input logic [7:0] mask, input logic [7:0] dwell);
        fq.push_back({dwell, mask});
        exp_q.push_back('{val: mask, pcnt: 16'(PULSE), gcnt: 16'(dwell) * 16'(TDIV),
                          gbad: 1'b0, period: 16'(2 + PULSE) + 16'(dwell) * 16'(TDIV)});
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (steps !== 8'h00) begin errors++; $display("FAIL reset_steps got %h want 00", steps); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
        if (records_done !== 16'h0) begin errors++; $display("FAIL reset_records got %h want 0000", records_done); end
        if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en got %b want 0", fifo_read_en); end
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        rec_t e, o;
        int   p0 = pops;
        push_rec(8'h05, 8'd2);
        wait_obs(1, 200);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin errors++; $display("FAIL single_timeout got 0 records want 1"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++;
                $display("FAIL single_rec got val=%h pulse=%0d gap=%0d gbad=%0d period=%0d want val=%h pulse=%0d gap=%0d period=%0d",
                         o.val, o.pcnt, o.gcnt, o.gbad, o.period, e.val, e.pcnt, e.gcnt, e.period);
            end
        end
        checks += 4;
        if (pops - p0 != 1) begin errors++; $display("FAIL single_pops got %0d want 1", pops - p0); end
        if (records_done !== 16'd1) begin errors++; $display("FAIL single_records got %0d want 1", records_done); end
        if (underrun !== 1'b1) begin errors++; $display("FAIL single_underrun got %b want 1", underrun); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        rec_t e, o;
        int   p0 = pops;
        logic [15:0] r0 = records_done;
        push_rec(8'h01, 8'd0);
        push_rec(8'h02, 8'd0);
        push_rec(8'h80, 8'd0);
        wait_obs(3, 300);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() < 3) begin errors++; $display("FAIL b2b_timeout got %0d records want 3", obs_q.size()); end
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front(); checks++;
                if (o !== e) begin errors++;
                    $display("FAIL b2b_rec%0d got val=%h pulse=%0d gap=%0d gbad=%0d period=%0d want val=%h pulse=%0d gap=%0d period=%0d",
                             k, o.val, o.pcnt, o.gcnt, o.gbad, o.period, e.val, e.pcnt, e.gcnt, e.period);
                end
            end
        end
        checks += 2;
        if (pops - p0 != 3) begin errors++; $display("FAIL b2b_pops got %0d want 3", pops - p0); end
        if (records_done - r0 !== 16'd3) begin errors++; $display("FAIL b2b_records got %0d want 3", records_done - r0); end
    endtask

    task automatic test_enable_drop;
        rec_t e, o;
        int   p0 = pops;
        push_rec(8'hFF, 8'd1);
        push_rec(8'h11, 8'd0);
        for (int i = 0; i < 50 && steps !== 8'hFF; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_obs(1, 200);
        repeat (30) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin errors++; $display("FAIL drop_timeout got 0 records want 1"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++;
                $display("FAIL drop_rec got val=%h pulse=%0d gap=%0d gbad=%0d period=%0d want val=%h pulse=%0d gap=%0d period=%0d",
                         o.val, o.pcnt, o.gcnt, o.gbad, o.period, e.val, e.pcnt, e.gcnt, e.period);
            end
        end
        checks += 3;
        if (pops - p0 != 1) begin errors++; $display("FAIL drop_pops got %0d want 1", pops - p0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL drop_underrun got %b want 0", underrun); end
    endtask

    task automatic test_reset_mid_pulse;
        rec_t e, o;
        int   p0;
        enable = 1'b1;
        for (int i = 0; i < 50 && steps !== 8'h11; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        push_rec(8'h22, 8'd1);
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (steps !== 8'h00) begin errors++; $display("FAIL rstmid_steps got %h want 00", steps); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (records_done !== 16'h0) begin errors++; $display("FAIL rstmid_records got %h want 0000", records_done); end
        p0 = pops;
        repeat (5) @(negedge clk);
        checks++;
        if (pops != p0) begin errors++; $display("FAIL rstmid_read_en got %0d pops want 0", pops - p0); end
        reset = 1'b0;
        void'(exp_q.pop_front());
        wait_obs(1, 200);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin errors++; $display("FAIL rstmid_timeout got 0 records want 1"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++;
                $display("FAIL rstmid_rec got val=%h pulse=%0d gap=%0d gbad=%0d period=%0d want val=%h pulse=%0d gap=%0d period=%0d",
                         o.val, o.pcnt, o.gcnt, o.gbad, o.period, e.val, e.pcnt, e.gcnt, e.period);
            end
        end
        checks++;
        if (records_done !== 16'd1) begin errors++; $display("FAIL rstmid_after got %0d want 1", records_done); end
    endtask

    task automatic test_starve_long_dwell;
        rec_t e, o;
        int   p0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        p0 = pops;
        repeat (100) @(negedge clk);
        checks += 2;
        if (pops != p0) begin errors++; $display("FAIL starve_pops got %0d want 0", pops - p0); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL starve_underrun got %b want 0", underrun); end
        push_rec(8'h00, 8'd255);
        wait_obs(1, 4000);
        checks++;
        if (obs_q.size() < 1) begin errors++; $display("FAIL starve_timeout got 0 records want 1"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++;
                $display("FAIL starve_rec got val=%h pulse=%0d gap=%0d gbad=%0d period=%0d want val=%h pulse=%0d gap=%0d period=%0d",
                         o.val, o.pcnt, o.gcnt, o.gbad, o.period, e.val, e.pcnt, e.gcnt, e.period);
            end
        end
    endtask

    task automatic test_records_wrap;
        rec_t e, o;
        @(negedge clk);
        force dut.records_done = 16'hFFFF;
        @(negedge clk);
        release dut.records_done;
        push_rec(8'h03, 8'd0);
        wait_obs(1, 200);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin errors++; $display("FAIL wrap_timeout got 0 records want 1"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++;
                $display("FAIL wrap_rec got val=%h pulse=%0d gap=%0d gbad=%0d period=%0d want val=%h pulse=%0d gap=%0d period=%0d",
                         o.val, o.pcnt, o.gcnt, o.gbad, o.period, e.val, e.pcnt, e.gcnt, e.period);
            end
        end
        checks++;
        if (records_done !== 16'h0000) begin errors++; $display("FAIL wrap_records got %h want 0000", records_done); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_enable_drop;
        test_reset_mid_pulse;
        test_starve_long_dwell;
        test_records_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
